exhaustive_vector_sequencer: RTL and testbench

- Controller that drives a small benchmark DUT (N_IN data inputs, N_OUT outputs, shared CK) through every input vector 0 … 2^N_IN−1 in ascending order.
- For each vector it waits a settle window, captures the DUT response, and emits a {vector, response} record on a valid/ready stream to the logging/comparison side.
- Replaces fixed-delay bench stimulus with a synthesizable, backpressure-aware sequencer usable for golden-vs-suspect (trojan) response collection.

---
 rtl/exhaustive_vector_sequencer_pkg.sv | 14 +
 rtl/exhaustive_vector_sequencer_if.sv | 13 +
 rtl/exhaustive_vector_sequencer_misr.sv | 31 +++
 rtl/exhaustive_vector_sequencer.sv | 131 +++++++++++++
 tb/tb_exhaustive_vector_sequencer.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/exhaustive_vector_sequencer_pkg.sv
// Shared types and constants for the exhaustive vector sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_EMIT,
    S_DONE
  } seq_state_e;

  localparam logic [15:0] MISR_POLY = 16'h1021;

endpackage

// File: rtl/exhaustive_vector_sequencer_if.sv
// Record stream between the sequencer and the logging/comparison side.
interface exhaustive_vector_sequencer_if #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 1
);
  logic             rec_valid;
  logic             rec_ready;
  logic [N_IN-1:0]  rec_vec;
  logic [N_OUT-1:0] rec_resp;

  modport master (output rec_valid, rec_vec, rec_resp, input rec_ready);
  modport slave  (input rec_valid, rec_vec, rec_resp, output rec_ready);
endinterface

// File: rtl/exhaustive_vector_sequencer_misr.sv
// Signature register folding each accepted record into a shift-XOR MISR.
module seq_misr #(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = '0
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [SIG_W-1:0] data,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_d, sig_q;

  always_comb begin
    sig_d = sig_q;
    if (clear)
      sig_d = '0;
    else if (en)
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ data;
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/exhaustive_vector_sequencer.sv
// Sweeps a DUT through all 2^N_IN input vectors and streams {vector, response} records.
// Optional signature collection is enabled with `define SEQ_MISR_EN.
module exhaustive_vector_sequencer
  import seq_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 1,
  parameter int SIG_W  = 16
) (
  input  logic                          CK,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [N_IN-1:0]               dut_in,
  input  logic [N_OUT-1:0]              dut_out,
  exhaustive_vector_sequencer_if.master rec,
  output logic [SIG_W-1:0]              sig
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE);

  seq_state_e       state_d, state_q;
  logic [N_IN-1:0]  vec_d, vec_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             rec_valid_d, rec_valid_q;
  logic [N_IN-1:0]  rec_vec_d, rec_vec_q;
  logic [N_OUT-1:0] rec_resp_d, rec_resp_q;

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    rec_valid_d = rec_valid_q;
    rec_vec_d   = rec_vec_q;
    rec_resp_d  = rec_resp_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d   = '0;
          cnt_d   = CNT_INIT;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        rec_resp_d  = dut_out;
        rec_vec_d   = vec_q;
        rec_valid_d = 1'b1;
        state_d     = S_EMIT;
      end
      S_EMIT: begin
        if (rec.rec_ready) begin
          rec_valid_d = 1'b0;
          // last vector is checked before incrementing so vec never wraps
          if (&vec_q) begin
            state_d = S_DONE;
          end else begin
            vec_d   = vec_q + N_IN'(1);
            cnt_d   = CNT_INIT;
            state_d = S_SETTLE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rec_valid_q <= 1'b0;
      rec_vec_q   <= '0;
      rec_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rec_valid_q <= rec_valid_d;
      rec_vec_q   <= rec_vec_d;
      rec_resp_q  <= rec_resp_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign dut_in       = vec_q;
  assign rec.rec_valid = rec_valid_q;
  assign rec.rec_vec   = rec_vec_q;
  assign rec.rec_resp  = rec_resp_q;

`ifdef SEQ_MISR_EN
  logic             misr_clear, misr_en;
  logic [SIG_W-1:0] misr_data;

  assign misr_clear = (state_q == S_IDLE) && start;
  assign misr_en    = (state_q == S_EMIT) && rec.rec_ready;
  assign misr_data  = SIG_W'({rec_vec_q, rec_resp_q});

  seq_misr #(
    .SIG_W (SIG_W),
    .POLY  (SIG_W'(MISR_POLY))
  ) u_misr (
    .CK    (CK),
    .reset (reset),
    .clear (misr_clear),
    .en    (misr_en),
    .data  (misr_data),
    .sig   (sig)
  );
`else
  assign sig = '0;
`endif

endmodule

// File: tb/tb_exhaustive_vector_sequencer.sv
// Directed bench: instance 0 (SETTLE=1, registered AND DUT), instance 1 (SETTLE=0, registered XOR DUT).
module tb_exhaustive_vector_sequencer;

`ifdef SEQ_MISR_EN
  localparam bit MISR = 1'b1;
`else
  localparam bit MISR = 1'b0;
`endif

  logic CK = 1'b0;
  logic reset = 1'b0;
  logic [1:0]       start_s = '0, rdy_s = '1;
  logic [1:0]       busy_w, done_w, valid_w, resp_w;
  logic [1:0][1:0]  din_w, vec_w;
  logic [1:0][15:0] sig_w;
  logic [0:0]       dq_a, dq_b;
  int nchk = 0, npass = 0;

  always #5 CK = ~CK;

  exhaustive_vector_sequencer_if #(.N_IN(2), .N_OUT(1)) ia ();
  exhaustive_vector_sequencer_if #(.N_IN(2), .N_OUT(1)) ib ();

  assign ia.rec_ready = rdy_s[0];
  assign ib.rec_ready = rdy_s[1];
  assign valid_w[0] = ia.rec_valid;
  assign valid_w[1] = ib.rec_valid;
  assign vec_w[0]   = ia.rec_vec;
  assign vec_w[1]   = ib.rec_vec;
  assign resp_w[0]  = ia.rec_resp[0];
  assign resp_w[1]  = ib.rec_resp[0];

  exhaustive_vector_sequencer #(.N_IN(2), .N_OUT(1), .SETTLE(1), .SIG_W(16)) dut_a (
    .CK(CK), .reset(reset), .start(start_s[0]), .busy(busy_w[0]), .done(done_w[0]),
    .dut_in(din_w[0]), .dut_out(dq_a), .rec(ia), .sig(sig_w[0])
  );

  exhaustive_vector_sequencer #(.N_IN(2), .N_OUT(1), .SETTLE(0), .SIG_W(16)) dut_b (
    .CK(CK), .reset(reset), .start(start_s[1]), .busy(busy_w[1]), .done(done_w[1]),
    .dut_in(din_w[1]), .dut_out(dq_b), .rec(ib), .sig(sig_w[1])
  );

  // benchmark DUTs: combinational function followed by one register
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      dq_a <= '0;
      dq_b <= '0;
    end else begin
      dq_a <= din_w[0][1] & din_w[0][0];
      dq_b <= din_w[1][1] ^ din_w[1][0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic exp_resp(input int sel, input int v);
    logic [1:0] b;
    b = v[1:0];
    return (sel == 0) ? (b[1] & b[0]) : (b[1] ^ b[0]);
  endfunction

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
  endfunction

  task automatic chk_zero(input int sel, input string tag);
    chk({tag, "_busy"},  busy_w[sel],  0);
    chk({tag, "_done"},  done_w[sel],  0);
    chk({tag, "_valid"}, valid_w[sel], 0);
    chk({tag, "_dutin"}, din_w[sel],   0);
    chk({tag, "_vec"},   vec_w[sel],   0);
    chk({tag, "_resp"},  resp_w[sel],  0);
    chk({tag, "_sig"},   sig_w[sel],   0);
  endtask

  // One sweep; stall_vec holds rec_ready low 5 cycles on that record, poke_vec pulses start mid-sweep.
  task automatic sweep(input int sel, input int settle, input int stall_vec, input int poke_vec,
                       input bit keep_start, input logic [15:0] final_sig);
    int nrec, stall, done_k, exp_k, pv;
    bit seen, hs;
    logic pr;
    logic [15:0] msig;
    nrec = 0; stall = 0; done_k = -1; seen = 0; hs = 0; msig = '0; pv = 0; pr = 1'b0;
    start_s[sel] = 1'b1;
    rdy_s[sel]   = 1'b1;
    for (int i = 0; i < 10 && busy_w[sel]; i++) @(negedge CK);
    chk("idle_before_start", busy_w[sel], 0);
    @(posedge CK);
    #1 start_s[sel] = keep_start;
    for (int k = 0; k < 100; k++) begin
      @(negedge CK);
      if (hs) begin
        msig = misr(msig, {13'b0, pv[1:0], pr});
        chk("sig_step", sig_w[sel], MISR ? msig : 16'h0);
        hs = 1'b0;
      end
      if (done_w[sel]) begin
        done_k = k;
        break;
      end
      chk("busy", busy_w[sel], 1);
      if (nrec < 4) chk("dut_in", din_w[sel], nrec);
      if (valid_w[sel]) begin
        if (!seen) begin
          exp_k = settle + 2 + nrec * (settle + 3) + ((stall_vec >= 0 && nrec > stall_vec) ? 5 : 0);
          chk("rec_cycle", k, exp_k);
          seen = 1'b1;
        end
        chk("rec_vec", vec_w[sel], nrec);
        chk("rec_resp", resp_w[sel], exp_resp(sel, nrec));
        if (nrec == stall_vec && stall < 5) begin
          rdy_s[sel] = 1'b0;
          stall++;
        end else begin
          rdy_s[sel] = 1'b1;
          hs = 1'b1;
          pv = nrec;
          pr = exp_resp(sel, nrec);
          nrec++;
          seen = 1'b0;
        end
      end
      start_s[sel] = keep_start | (nrec == poke_vec);
    end
    chk("done_cycle", done_k, 4 * (settle + 3) + ((stall_vec >= 0) ? 5 : 0));
    chk("num_records", nrec, 4);
    chk("dut_in_no_wrap", din_w[sel], 3);
    chk("final_sig", sig_w[sel], MISR ? final_sig : 16'h0);
    if (!keep_start) begin
      @(negedge CK);
      chk("done_one_cycle", done_w[sel], 0);
      chk("idle_after_done", busy_w[sel], 0);
      chk("sig_held", sig_w[sel], MISR ? final_sig : 16'h0);
    end
  endtask

  task automatic reset_test();
    int ndone;
    ndone = 0;
    start_s[0] = 1'b1;
    @(posedge CK);
    #1 start_s[0] = 1'b0;
    for (int k = 0; k <= 8; k++) @(negedge CK);
    chk("pre_reset_dut_in", din_w[0], 2);
    chk("pre_reset_busy", busy_w[0], 1);
    chk("pre_reset_vec", vec_w[0], 1);
    reset = 1'b0;
    #1;
    chk_zero(0, "async_rst");
    @(negedge CK);
    @(negedge CK);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CK);
      if (done_w[0]) ndone++;
    end
    chk("post_reset_no_done", ndone, 0);
    chk("post_reset_idle", busy_w[0], 0);
    chk("post_reset_dut_in", din_w[0], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge CK);
    chk_zero(0, "reset_a");
    chk_zero(1, "reset_b");
    reset = 1'b1;
    @(negedge CK);
    // AND DUT records (00,0) (01,0) (10,0) (11,1): sig 0 -> 2 -> 0 -> 7
    sweep(0, 1, -1, -1, 1'b0, 16'h0007);
    sweep(0, 1, 1, -1, 1'b0, 16'h0007);
    sweep(0, 1, -1, 2, 1'b0, 16'h0007);
    // XOR DUT records (00,0) (01,1) (10,1) (11,0): sig 0 -> 3 -> 3 -> 0; start held into a second sweep
    sweep(1, 0, -1, -1, 1'b1, 16'h0000);
    sweep(1, 0, -1, -1, 1'b0, 16'h0000);
    reset_test();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
